stepper_pulse_generator: RTL and testbench
==========================================

STEPPER_PULSE_GENERATOR -- requirements
Module: stepper_pulse_generator

Interface
REQ-001 SHALL have parameter width, 32, bit width of step_count and steps_remaining.
REQ-002 SHALL have parameter pulse_cycles, 50, step high time in clock_in cycles (1 us at 50 MHz); legal range >= 1.
REQ-003 SHALL have parameter dir_setup_cycles, 10, dir-to-first-step setup time in clock_in cycles; legal range >= 1.
REQ-004 SHALL have port clock_in  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port step_clock  input  1  step-rate clock from the upstream clock generator, synchronous to clock_in.
REQ-007 SHALL have port write  input  1  one-cycle move command strobe.
REQ-008 SHALL have port step_count  input  width  number of steps in the move, sampled on write.
REQ-009 SHALL have port direction  input  1  move direction, sampled on write.
REQ-010 SHALL have port abort  input  1  stop request.
REQ-011 SHALL have port step  output  1  registered step pulse to the motor driver.
REQ-012 SHALL have port dir  output  1  registered direction to the motor driver.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port overrun  output  1  sticky flag: a step_clock rising edge arrived while in PULSE.
REQ-016 SHALL have port steps_remaining  output  width  steps not yet issued.

Function
REQ-017 SHALL detect step_clock rising edges as step_clock==1 with the previous registered sample==0; the sample register runs in every state.
REQ-018 SHALL implement FSM states IDLE, DIR_SETUP, WAIT_EDGE, PULSE.
REQ-019 IDLE, write=1, abort=0, step_count!=0: latch steps_remaining<=step_count, dir<=direction, timer<=dir_setup_cycles-1, clear overrun, go to DIR_SETUP.
REQ-020 IDLE, write=1, step_count==0: no state change, no dir change; done=1 on the next cycle.
REQ-021 DIR_SETUP: decrement timer; at timer==0 go to WAIT_EDGE; edges seen in DIR_SETUP are discarded.
REQ-022 WAIT_EDGE, edge detected: step<=1, timer<=pulse_cycles-1, go to PULSE (step rises 1 cycle after the edge-detect cycle).
REQ-023 PULSE: decrement timer; at timer==0 step<=0 and steps_remaining decrements by 1; if steps_remaining was 1, go to IDLE with done=1, else go to WAIT_EDGE.
REQ-024 step SHALL stay high for exactly pulse_cycles clock_in cycles; no runt pulses under any input sequence except reset.
REQ-025 An edge detected in PULSE SHALL be dropped and set overrun=1, which holds until the next accepted write or reset.
REQ-026 write while busy=1 SHALL be ignored with no effect on any register.
REQ-027 abort in DIR_SETUP or WAIT_EDGE: go to IDLE next cycle with done=1; steps_remaining holds the unissued count.
REQ-028 abort in PULSE: latch abort_pending; complete the pulse per REQ-023, then go to IDLE with done=1 regardless of the remaining count.
REQ-029 abort and write in the same IDLE cycle: abort wins and write is ignored; abort in IDLE alone has no effect and no done pulse.
REQ-030 dir SHALL change only on an accepted write (REQ-019).
REQ-031 steps_remaining SHALL never wrap below 0.

Reset
REQ-032 reset=1 SHALL asynchronously force state=IDLE, step=0, dir=0, done=0, overrun=0, steps_remaining=0, timer=0, abort_pending=0, edge sample=0.
REQ-033 reset mid-PULSE SHALL drop step immediately without waiting for a clock edge.

Structure
REQ-034 Package menlo_cnc_pkg SHALL hold the FSM state enum typedef and the default pulse_cycles/dir_setup_cycles constants.
REQ-035 Rising-edge detection SHALL be a sub-module, rising_edge_detect (clock_in, reset, d, rise).

Verification
REQ-036 step_count=3, direction=1, step_clock period 200 cycles -> dir=1 before the first step, 3 step pulses each 50 cycles high, done=1 for one cycle, busy=0, steps_remaining=0.
REQ-037 write with step_count=0 -> done pulses once, busy stays 0, dir unchanged.
REQ-038 step_count=5, abort 10 cycles into the 2nd pulse -> 2nd pulse still 50 cycles, no 3rd pulse, done=1, steps_remaining=3.
REQ-039 step_clock period 20 cycles with pulse_cycles=50 -> overrun=1, each pulse 50 cycles; overrun clears on the next write.
REQ-040 second write mid-move with step_count=9, direction=0 -> ignored; the original count completes and dir is unchanged.
REQ-041 reset asserted mid-PULSE between clock edges -> step=0 and busy=0 immediately; a new write afterward runs normally.

Source files
------------

// File: rtl/menlo_cnc_pkg.sv
// Shared definitions for the CNC motion blocks: step generator FSM states
// and default timing constants (50 MHz clock_in).
package menlo_cnc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        WAIT_EDGE = 2'd2,
        PULSE     = 2'd3
    } step_state_t;

    localparam int DEFAULT_PULSE_CYCLES     = 50;
    localparam int DEFAULT_DIR_SETUP_CYCLES = 10;

endpackage

// File: rtl/rising_edge_detect.sv
// One-register rising-edge detector; the sample register runs continuously
// so an edge is seen exactly once regardless of the consumer's state.
module rising_edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= d;
        end
    end

    assign rise = d & ~r_prev;

endmodule

// File: rtl/stepper_pulse_generator.sv
// Turns a move command (count, direction) into fixed-width step pulses, one per
// accepted step_clock rising edge, after a direction setup delay.
module stepper_pulse_generator
    import menlo_cnc_pkg::*;
#(
    parameter int width            = 32,
    parameter int pulse_cycles     = DEFAULT_PULSE_CYCLES,
    parameter int dir_setup_cycles = DEFAULT_DIR_SETUP_CYCLES
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             step_clock,
    input  logic             write,
    input  logic [width-1:0] step_count,
    input  logic             direction,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [width-1:0] steps_remaining
);

    localparam logic [31:0]      PULSE_LOAD = 32'(pulse_cycles - 1);
    localparam logic [31:0]      SETUP_LOAD = 32'(dir_setup_cycles - 1);
    localparam logic [width-1:0] ONE        = width'(1);

    step_state_t      r_state;
    logic             r_step;
    logic             r_dir;
    logic             r_done;
    logic             r_overrun;
    logic             r_abort_pending;
    logic [width-1:0] r_steps_rem;
    logic [31:0]      r_timer;

    step_state_t      w_state_nxt;
    logic             w_step_nxt;
    logic             w_dir_nxt;
    logic             w_done_nxt;
    logic             w_overrun_nxt;
    logic             w_abort_pending_nxt;
    logic [width-1:0] w_steps_rem_nxt;
    logic [31:0]      w_timer_nxt;
    logic             w_rise;

    rising_edge_detect u_edge (
        .clock_in (clock_in),
        .reset    (reset),
        .d        (step_clock),
        .rise     (w_rise)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_step          <= 1'b0;
            r_dir           <= 1'b0;
            r_done          <= 1'b0;
            r_overrun       <= 1'b0;
            r_abort_pending <= 1'b0;
            r_steps_rem     <= '0;
            r_timer         <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_step          <= w_step_nxt;
            r_dir           <= w_dir_nxt;
            r_done          <= w_done_nxt;
            r_overrun       <= w_overrun_nxt;
            r_abort_pending <= w_abort_pending_nxt;
            r_steps_rem     <= w_steps_rem_nxt;
            r_timer         <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_step_nxt          = r_step;
        w_dir_nxt           = r_dir;
        w_done_nxt          = 1'b0;
        w_overrun_nxt       = r_overrun;
        w_abort_pending_nxt = r_abort_pending;
        w_steps_rem_nxt     = r_steps_rem;
        w_timer_nxt         = r_timer;

        case (r_state)
            IDLE: begin
                // abort in the same cycle as write cancels the command outright
                if (write && !abort) begin
                    if (step_count != '0) begin
                        w_steps_rem_nxt     = step_count;
                        w_dir_nxt           = direction;
                        w_timer_nxt         = SETUP_LOAD;
                        w_overrun_nxt       = 1'b0;
                        w_abort_pending_nxt = 1'b0;
                        w_state_nxt         = DIR_SETUP;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            DIR_SETUP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_timer == '0) begin
                    w_state_nxt = WAIT_EDGE;
                end else begin
                    w_timer_nxt = r_timer - 32'd1;
                end
            end
            WAIT_EDGE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_rise) begin
                    w_step_nxt  = 1'b1;
                    w_timer_nxt = PULSE_LOAD;
                    w_state_nxt = PULSE;
                end
            end
            PULSE: begin
                // a pulse in flight always runs to full width; abort only ends the move after it
                if (w_rise) begin
                    w_overrun_nxt = 1'b1;
                end
                if (abort) begin
                    w_abort_pending_nxt = 1'b1;
                end
                if (r_timer == '0) begin
                    w_step_nxt = 1'b0;
                    if (r_steps_rem != '0) begin
                        w_steps_rem_nxt = r_steps_rem - ONE;
                    end
                    if ((r_steps_rem <= ONE) || abort || r_abort_pending) begin
                        w_state_nxt         = IDLE;
                        w_done_nxt          = 1'b1;
                        w_abort_pending_nxt = 1'b0;
                    end else begin
                        w_state_nxt = WAIT_EDGE;
                    end
                end else begin
                    w_timer_nxt = r_timer - 32'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign step            = r_step;
    assign dir             = r_dir;
    assign busy            = (r_state != IDLE);
    assign done            = r_done;
    assign overrun         = r_overrun;
    assign steps_remaining = r_steps_rem;

endmodule

// File: tb/tb_stepper_pulse_generator.sv
// Bench for stepper_pulse_generator: idle command table, directed move
// scenarios and randomized moves checked against a timeline model.
module tb_stepper_pulse_generator;

    localparam int P    = 50;
    localparam int D    = 10;
    localparam int W    = 32;
    localparam int MAXR = 2048;

    typedef struct {
        bit          wr;
        int unsigned cnt;
        bit          dirn;
        bit          ab;
        bit          e_busy;
        bit          e_done;
        bit          e_dir;
        int unsigned e_rem;
    } vec_t;

    logic         clock_in   = 1'b0;
    logic         reset      = 1'b1;
    logic         step_clock = 1'b0;
    logic         write      = 1'b0;
    logic [W-1:0] step_count = '0;
    logic         direction  = 1'b0;
    logic         abort      = 1'b0;
    logic         step;
    logic         dir;
    logic         busy;
    logic         done;
    logic         overrun;
    logic [W-1:0] steps_remaining;

    int checks   = 0;
    int failures = 0;

    bit sc_arr[MAXR];
    bit rise_arr[MAXR];

    always #5 clock_in = ~clock_in;

    stepper_pulse_generator #(
        .width            (W),
        .pulse_cycles     (P),
        .dir_setup_cycles (D)
    ) dut (
        .clock_in        (clock_in),
        .reset           (reset),
        .step_clock      (step_clock),
        .write           (write),
        .step_count      (step_count),
        .direction       (direction),
        .abort           (abort),
        .step            (step),
        .dir             (dir),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun),
        .steps_remaining (steps_remaining)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock_in);
        @(negedge clock_in);
    endtask

    // Relative cycle r = index of the posedge after the write posedge (r=0).
    task automatic run_move(input int n, input bit d, input int period, input int high,
                            input int phase, input int abort_rel, input int wr2_in,
                            output int act_pulses, output int act_rem, output bit act_ovr);
        int exp_done, exp_rem, t, e, r_end, wr2, hi, done_r, done_cnt, busy_bad;
        bit exp_ovr, pend, stop, prev_step;
        int exp_starts[$];
        int act_starts[$];

        sc_arr[0]   = 1'b0;
        rise_arr[0] = 1'b0;
        for (int r = 1; r < MAXR; r++) begin
            sc_arr[r]   = ((((r - phase) % period) + period) % period) < high;
            rise_arr[r] = sc_arr[r] && !sc_arr[r-1];
        end

        exp_rem  = n;
        exp_ovr  = 1'b0;
        exp_done = MAXR - 8;
        if (abort_rel >= 1 && abort_rel <= D) begin
            exp_done = abort_rel;
        end else begin
            t    = D + 1;
            stop = 1'b0;
            while (!stop && t < MAXR - 8 - P) begin
                if (t == abort_rel) begin
                    exp_done = t;
                    stop     = 1'b1;
                end else if (rise_arr[t]) begin
                    e = t;
                    exp_starts.push_back(e);
                    pend = 1'b0;
                    for (int k = e + 1; k <= e + P; k++) begin
                        if (rise_arr[k]) exp_ovr = 1'b1;
                        if (k == abort_rel) pend = 1'b1;
                    end
                    exp_rem--;
                    if (exp_rem == 0 || pend) begin
                        exp_done = e + P;
                        stop     = 1'b1;
                    end else begin
                        t = e + P + 1;
                    end
                end else begin
                    t++;
                end
            end
        end
        wr2   = (wr2_in > 0 && wr2_in < exp_done) ? wr2_in : -1;
        r_end = exp_done + 4;

        write      = 1'b1;
        step_count = W'(n);
        direction  = d;
        abort      = 1'b0;
        step_clock = 1'b0;
        cycle();
        write = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_overrun_clear", overrun, 0);
        chk("accept_dir", dir, d);
        chk("accept_rem", steps_remaining, n);

        hi = 0; done_r = -1; done_cnt = 0; busy_bad = 0; prev_step = 1'b0;
        for (int r = 1; r <= r_end; r++) begin
            step_clock = sc_arr[r];
            abort      = (r == abort_rel);
            if (r == wr2) begin
                write      = 1'b1;
                step_count = W'(9);
                direction  = 1'b0;
            end else begin
                write = 1'b0;
            end
            cycle();
            if (step && !prev_step) act_starts.push_back(r);
            if (step) hi++;
            if (!step && prev_step) begin
                chk("pulse_width", hi, P);
                hi = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_r < 0) done_r = r;
            end
            if (busy != (r < exp_done)) busy_bad++;
            prev_step = step;
        end
        step_clock = 1'b0;
        abort      = 1'b0;
        write      = 1'b0;

        chk("pulse_count", act_starts.size(), exp_starts.size());
        for (int i = 0; i < exp_starts.size() && i < act_starts.size(); i++)
            chk("pulse_start", act_starts[i], exp_starts[i]);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_r, exp_done);
        chk("busy_profile", busy_bad, 0);
        chk("final_rem", steps_remaining, exp_rem);
        chk("final_overrun", overrun, exp_ovr);
        chk("final_dir", dir, d);
        chk("final_busy", busy, 0);
        chk("final_step", step, 0);
        act_pulses = act_starts.size();
        act_rem    = int'(steps_remaining);
        act_ovr    = overrun;
    endtask

    initial begin
        int   np, nr, per, hig, ph, ab, w2;
        bit   no;
        vec_t tbl[10];

        //          wr  cnt dir ab  busy done dir rem
        tbl[0] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[5] = '{1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4};
        tbl[6] = '{1'b1, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4};
        tbl[7] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4};
        tbl[8] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        tbl[9] = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4};

        reset = 1'b1;
        cycle();
        cycle();
        chk("reset_step", step, 0);
        chk("reset_dir", dir, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_rem", steps_remaining, 0);
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 10; i++) begin
            write      = tbl[i].wr;
            step_count = W'(tbl[i].cnt);
            direction  = tbl[i].dirn;
            abort      = tbl[i].ab;
            cycle();
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("tbl%0d_dir", i), dir, tbl[i].e_dir);
            chk($sformatf("tbl%0d_rem", i), steps_remaining, tbl[i].e_rem);
        end
        write = 1'b0;
        abort = 1'b0;
        cycle();

        // three-step move, 200-cycle step clock
        run_move(3, 1'b1, 200, 100, 20, -1, -1, np, nr, no);
        chk("basic_pulses", np, 3);
        chk("basic_rem", nr, 0);

        // abort 10 cycles into the second pulse (second edge at r=220)
        run_move(5, 1'b1, 200, 100, 20, 230, -1, np, nr, no);
        chk("abort_pulses", np, 2);
        chk("abort_rem", nr, 3);

        // step clock faster than the pulse: overrun, then cleared by the next move
        run_move(3, 1'b0, 20, 10, 5, -1, -1, np, nr, no);
        chk("overrun_set", no, 1);
        run_move(2, 1'b1, 200, 100, 20, -1, -1, np, nr, no);
        chk("overrun_cleared", no, 0);

        // second write mid-move is ignored
        run_move(3, 1'b1, 200, 100, 20, -1, 100, np, nr, no);
        chk("wr2_pulses", np, 3);
        chk("wr2_rem", nr, 0);

        // asynchronous reset in the middle of a pulse
        write      = 1'b1;
        step_count = W'(3);
        direction  = 1'b1;
        cycle();
        write = 1'b0;
        for (int r = 1; r <= 40; r++) begin
            step_clock = (r >= 20 && r < 120);
            cycle();
        end
        chk("pre_reset_step", step, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_step", step, 0);
        chk("async_busy", busy, 0);
        step_clock = 1'b0;
        cycle();
        chk("rst_dir", dir, 0);
        chk("rst_rem", steps_remaining, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        cycle();
        run_move(2, 1'b1, 150, 60, 30, -1, -1, np, nr, no);
        chk("post_reset_pulses", np, 2);

        for (int it = 0; it < 12; it++) begin
            per = $urandom_range(250, 15);
            hig = $urandom_range(per - 1, 1);
            ph  = $urandom_range(per, 1);
            ab  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(600, 1)) : -1;
            w2  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(400, 1)) : -1;
            run_move(int'($urandom_range(5, 1)), 1'($urandom_range(1, 0)), per, hig, ph, ab, w2,
                     np, nr, no);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
